// File: rtl/video_source_switch_pkg.sv
// ----------------------------------------------------------------------------
// vss_pkg
// Shared definitions for the video source switcher:
//   - vss_state_t      : switch FSM states (IDLE, WAIT_VS, BLANK)
//   - seg_idle_default : builds the default blanked segment pattern
//                        (digit selects all 0, segments all 1 = off on an
//                        active-low display)
//   - sel_w            : width of a select bus able to address n sources
// ----------------------------------------------------------------------------
package vss_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        BLANK   = 2'd2
    } vss_state_t;

    // Low led_w bits set, everything above clear. The caller casts the
    // result to the full {seg_select, seg_LED} width.
    function automatic logic [31:0] seg_idle_default(input int led_w);
        logic [31:0] pat;
        pat = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < led_w) begin
                pat[i] = 1'b1;
            end
        end
        return pat;
    endfunction

    // A single source still gets a 1-bit select so the port never collapses.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/video_source_switch_vs_edge_det.sv
// ----------------------------------------------------------------------------
// vs_edge_det
// Delay flop and falling-edge pulse for the active-low vsync of the source
// currently selected by the switcher.
//
// Ports:
//   clk      in  1  system clock
//   rst_n    in  1  asynchronous active-low reset (delay flop resets to 1,
//                   i.e. sync inactive, so no edge is seen out of reset)
//   vs_in    in  1  vsync of the source driving the outputs this cycle
//   load     in  1  the selected source changes at the coming edge
//   load_val in  1  vsync of the source that becomes selected
//   vs_fall  out 1  combinational pulse: vs_d high and vs_in low
// ----------------------------------------------------------------------------
module vs_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic vs_in,
    input  logic load,
    input  logic load_val,
    output logic vs_fall
);

    logic vs_d;

    // When the selection changes, the delay flop is reloaded from the new
    // source so the first comparison after the change is new-vs-new and a
    // level difference between the two sources cannot look like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b1;
        end else if (load) begin
            vs_d <= load_val;
        end else begin
            vs_d <= vs_in;
        end
    end

    assign vs_fall = vs_d & ~vs_in;

endmodule

// File: rtl/video_source_switch.sv
// ----------------------------------------------------------------------------
// video_source_switch
// Frame-synchronous N-source switcher for the VGA and 7-segment outputs.
// A new selection only takes effect on a vsync falling edge of the source
// currently on screen, after which BLANK_FRAMES frames of the new source are
// sent with black RGB and idle segments, so the monitor never sees a torn
// frame.
//
// Optional build macro:
//   SWITCH_TIMEOUT_EN  adds a cycle counter so a dead source (no vsync) cannot
//                      hold the switch in WAIT_VS or BLANK forever; after
//                      TIMEOUT_CYC cycles without a vsync edge the FSM moves on.
//
// Ports:
//   sys_clk     in  1                  system clock (all sources synchronous)
//   sys_rst_n   in  1                  asynchronous active-low reset
//   sel_req     in  SEL_W              requested source, level-sensitive;
//                                      values >= NUM_SRC are ignored
//   src_rgb     in  NUM_SRC*RGB_W      packed RGB, source k at [k*RGB_W +: RGB_W]
//   src_hs      in  NUM_SRC            per-source hsync (active-low)
//   src_vs      in  NUM_SRC            per-source vsync (active-low)
//   src_seg_sel in  NUM_SRC*SEG_SEL_W  packed digit selects
//   src_seg_led in  NUM_SRC*SEG_LED_W  packed segments
//   rgb_out     out RGB_W              registered RGB
//   vga_h       out 1                  registered hsync
//   vga_v       out 1                  registered vsync
//   seg_select  out SEG_SEL_W          registered digit select
//   seg_LED     out SEG_LED_W          registered segments
//   active_src  out SEL_W              source currently driving the syncs
//   switching   out 1                  high while in WAIT_VS or BLANK
// ----------------------------------------------------------------------------
module video_source_switch
    import vss_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int RGB_W        = 12,
    parameter int SEG_SEL_W    = 4,
    parameter int SEG_LED_W    = 7,
    parameter int BLANK_FRAMES = 2,
    parameter logic [SEG_SEL_W+SEG_LED_W-1:0] SEG_IDLE =
        (SEG_SEL_W+SEG_LED_W)'(seg_idle_default(SEG_LED_W)),
    parameter int TIMEOUT_CYC  = 2_000_000,
    localparam int SEL_W       = sel_w(NUM_SRC)
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic [SEL_W-1:0]               sel_req,
    input  logic [NUM_SRC*RGB_W-1:0]       src_rgb,
    input  logic [NUM_SRC-1:0]             src_hs,
    input  logic [NUM_SRC-1:0]             src_vs,
    input  logic [NUM_SRC*SEG_SEL_W-1:0]   src_seg_sel,
    input  logic [NUM_SRC*SEG_LED_W-1:0]   src_seg_led,
    output logic [RGB_W-1:0]               rgb_out,
    output logic                           vga_h,
    output logic                           vga_v,
    output logic [SEG_SEL_W-1:0]           seg_select,
    output logic [SEG_LED_W-1:0]           seg_LED,
    output logic [SEL_W-1:0]               active_src,
    output logic                           switching
);

    localparam logic [3:0] BLANK_LAST = 4'(BLANK_FRAMES);

    // ------------------------------------------------------------------
    // Unpacked views of the source buses
    // ------------------------------------------------------------------
    logic [RGB_W-1:0]     rgb_arr [NUM_SRC];
    logic [SEG_SEL_W-1:0] ssel_arr[NUM_SRC];
    logic [SEG_LED_W-1:0] sled_arr[NUM_SRC];

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
        assign rgb_arr[k]  = src_rgb[k*RGB_W +: RGB_W];
        assign ssel_arr[k] = src_seg_sel[k*SEG_SEL_W +: SEG_SEL_W];
        assign sled_arr[k] = src_seg_led[k*SEG_LED_W +: SEG_LED_W];
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    vss_state_t       state, state_nxt;
    logic [SEL_W-1:0] active_nxt;
    logic [SEL_W-1:0] pend, pend_nxt;
    logic [3:0]       blank_cnt, blank_cnt_nxt;
    logic             vs_fall;
    logic             tmo;
    logic             sel_ok;

    // Zero-extend before comparing so NUM_SRC == 2**SEL_W is handled.
    assign sel_ok = (32'(sel_req) < 32'(NUM_SRC));

    // ------------------------------------------------------------------
    // Vsync edge of the source on screen
    // ------------------------------------------------------------------
    vs_edge_det u_vs_edge_det (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .vs_in    (src_vs[active_src]),
        .load     (active_nxt != active_src),
        .load_val (src_vs[active_nxt]),
        .vs_fall  (vs_fall)
    );

    // ------------------------------------------------------------------
    // Optional dead-source timeout
    // ------------------------------------------------------------------
`ifdef SWITCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo = (tmo_cnt == TMO_W'(TIMEOUT_CYC));

    // Restarts on every frame edge and every state change; idles at 0 in IDLE.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt <= '0;
        end else if (state == IDLE || state_nxt != state || vs_fall) begin
            tmo_cnt <= '0;
        end else if (!tmo) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;

    assign tmo = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            active_src <= '0;
            pend       <= '0;
            blank_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            active_src <= active_nxt;
            pend       <= pend_nxt;
            blank_cnt  <= blank_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        active_nxt    = active_src;
        pend_nxt      = pend;
        blank_cnt_nxt = blank_cnt;

        case (state)
            // A vsync edge in this same cycle is deliberately ignored: the
            // request still has to wait for the following frame.
            IDLE: begin
                if (sel_ok && sel_req != active_src) begin
                    pend_nxt  = sel_req;
                    state_nxt = WAIT_VS;
                end
            end

            WAIT_VS: begin
                if (sel_ok) begin
                    pend_nxt = sel_req;
                end
                if (sel_ok && sel_req == active_src) begin
                    state_nxt = IDLE;
                end else if (vs_fall || tmo) begin
                    // Use this cycle's request so a late change still wins.
                    active_nxt    = pend_nxt;
                    blank_cnt_nxt = '0;
                    state_nxt     = BLANK;
                end
            end

            // sel_req is not looked at here; IDLE picks up any new request
            // one cycle after blanking ends.
            BLANK: begin
                if (vs_fall) begin
                    blank_cnt_nxt = blank_cnt + 4'd1;
                    if (blank_cnt + 4'd1 == BLANK_LAST) begin
                        state_nxt = IDLE;
                    end
                end else if (tmo) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign switching = (state != IDLE);

    // ------------------------------------------------------------------
    // Output registers
    // Steered by the next-state view so the registered outputs change on the
    // same edge as active_src/state: the cycle after the switching vsync edge
    // already shows the new source's syncs with black RGB.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rgb_out              <= '0;
            vga_h                <= 1'b1;
            vga_v                <= 1'b1;
            {seg_select, seg_LED} <= SEG_IDLE;
        end else begin
            vga_h <= src_hs[active_nxt];
            vga_v <= src_vs[active_nxt];
            if (state_nxt == BLANK) begin
                rgb_out               <= '0;
                {seg_select, seg_LED} <= SEG_IDLE;
            end else begin
                rgb_out    <= rgb_arr[active_nxt];
                seg_select <= ssel_arr[active_nxt];
                seg_LED    <= sled_arr[active_nxt];
            end
        end
    end

endmodule
